pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline register with a two-entry skid buffer, valid/ready handshake on both sides, and synchronous flush. Next generation of the plain enable register: sits between core pipeline stages (e.g. fetch→decode, LSU→cache request) where back-pressure must not create a combinational ready path. Sustains one transfer per cycle with fully registered outputs, including `s_ready_o`.

## Interface
- `DATA_WIDTH`, 64, payload width in bits
- `RESET_VAL`, '0 (`DATA_WIDTH` bits), value of `m_data_o` and of both internal data registers after reset
- `CNT_WIDTH`, 16, stall counter width; used only with `PIPE_SKID_REG_STALL_CNT_EN`

- `clk_i`  in  1  clock, rising edge
- `arst_i`  in  1  asynchronous, active-high reset
- `flush_i`  in  1  synchronous flush, drops all held entries
- `s_valid_i`  in  1  upstream data valid
- `s_ready_o`  out  1  block can accept; registered
- `s_data_i`  in  `DATA_WIDTH`  upstream payload
- `m_valid_o`  out  1  output holds valid data; registered
- `m_ready_i`  in  1  downstream accepts
- `m_data_o`  out  `DATA_WIDTH`  output payload; registered
- `stall_cnt_o`  out  `CNT_WIDTH`  output stall cycles; present only with the macro

## Operation
- Input transfer: `s_valid_i && s_ready_o`. Output transfer: `m_valid_o && m_ready_i`.
- Storage: main register (drives `m_data_o`/`m_valid_o`) and skid register.
- FSM, 3 states:
  - EMPTY: `m_valid_o=0`, `s_ready_o=1`. Input transfer → main ← `s_data_i`, go BUSY.
  - BUSY: `m_valid_o=1`, `s_ready_o=1`.
    - in and out → main ← `s_data_i`, stay BUSY.
    - in only → skid ← `s_data_i`, go FULL.
    - out only → go EMPTY.
    - neither → hold.
  - FULL: `m_valid_o=1`, `s_ready_o=0`. Out → main ← skid, go BUSY. Else hold.
- Ordering strictly FIFO; no entry dropped or duplicated except by flush.
- `m_data_o` stable while `m_valid_o && !m_ready_i`.
- Flush has highest priority: next state EMPTY, `s_ready_o=1`, `m_valid_o=0`. An input transfer in the flush cycle is discarded. Data registers hold their contents; no data reset on flush.
- Reset, asynchronous: state EMPTY, `m_valid_o=0`, `s_ready_o=1`, `m_data_o` and skid = `RESET_VAL`, `stall_cnt_o=0`.

## Timing
- Latency: input accepted at edge N is on `m_data_o` after edge N; visible in cycle N+1 when the block was EMPTY or BUSY with a simultaneous output transfer.
- Throughput: 1 transfer per cycle with `m_ready_i` held high.
- `s_ready_o` falls the cycle after the second entry is captured while the output is stalled. It rises the cycle after the FULL→BUSY drain edge.
- No combinational path from any input to any output.
- Reset deassertion: the first transfer is possible on the first rising edge after `arst_i` falls.

## Configuration
- Macro: `PIPE_SKID_REG_STALL_CNT_EN`.
- Defined:
  - `stall_cnt_o` exists.
  - Increments by 1 every cycle with `m_valid_o && !m_ready_i`.
  - Saturates at all-ones.
  - Cleared only by `arst_i`; flush does not clear it.
- Undefined: the port and counter logic are absent, and `CNT_WIDTH` is ignored. Datapath behaviour is identical in both builds.

## Test plan
- Reset mid-traffic: assert `arst_i` while FULL → immediately `m_valid_o=0`, `s_ready_o=1`, `m_data_o=RESET_VAL`. After release, first word 0xA5 appears on `m_data_o` one cycle after acceptance.
- Streaming: `m_ready_i=1`, send 0x1..0x10 back-to-back → 16 outputs in order on 16 consecutive cycles, `s_ready_o` constant 1.
- Back-pressure: `m_ready_i=0`, send 0x11, 0x22, 0x33 →
  - 0x11 and 0x22 are accepted; `s_ready_o=0` from the cycle after 0x22, so 0x33 waits.
  - Raising `m_ready_i` yields 0x11, 0x22, 0x33 in order, and `m_data_o` stays 0x11 while stalled.
- Flush while FULL, with `s_valid_i=1` carrying 0x44 in the flush cycle → next cycle `m_valid_o=0`, `s_ready_o=1`. 0x44 never appears on the output.
- Simultaneous in/out in BUSY: holding 0x55 with `m_ready_i=1` and input 0x66 → next cycle `m_data_o=0x66`, state BUSY, no skid use.
- Stall counter (macro on, `CNT_WIDTH=4`): hold an output stalled for 20 cycles → `stall_cnt_o` saturates at 15. A flush leaves it at 15; `arst_i` clears it to 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline register with a two-entry skid buffer, valid/ready
// handshake on both sides, synchronous flush and fully registered outputs.
// Ports: clk_i, arst_i (async, active-high), flush_i,
//   s_valid_i/s_ready_o/s_data_i (upstream), m_valid_o/m_ready_i/m_data_o
//   (downstream), stall_cnt_o (only with PIPE_SKID_REG_STALL_CNT_EN).
// Optional feature macro: PIPE_SKID_REG_STALL_CNT_EN (output stall counter).
module pipe_skid_reg #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = s_valid_i & s_ready_o;
  assign out_xfer = m_valid_o & m_ready_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush wins over everything and leaves the data registers untouched.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = s_data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = s_data_i;
          end else if (in_xfer) begin
            skid_d  = s_data_i;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs decode only the state flops, so no input reaches an output.
  always_comb begin
    m_valid_o = 1'b0;
    s_ready_o = 1'b1;
    unique case (state_q)
      EMPTY: begin
        m_valid_o = 1'b0;
        s_ready_o = 1'b1;
      end
      BUSY: begin
        m_valid_o = 1'b1;
        s_ready_o = 1'b1;
      end
      FULL: begin
        m_valid_o = 1'b1;
        s_ready_o = 1'b0;
      end
      default: begin
        m_valid_o = 1'b0;
        s_ready_o = 1'b1;
      end
    endcase
  end

  assign m_data_o = main_q;

`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Saturating; only the async reset clears it, flush does not.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (m_valid_o && !m_ready_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed stimulus, scoreboard queue filled on
// input transfers and drained by a monitor on output transfers.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          arst;
  logic          flush;
  logic          s_valid;
  logic          s_ready_o;
  logic [DW-1:0] s_data;
  logic          m_valid_o;
  logic          m_ready;
  logic [DW-1:0] m_data_o;
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [3:0]    stall_cnt;
`endif

  pipe_skid_reg #(
    .DATA_WIDTH(DW),
    .RESET_VAL ('0),
    .CNT_WIDTH (4)
  ) dut (
    .clk_i    (clk),
    .arst_i   (arst),
    .flush_i  (flush),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready_o),
    .s_data_i (s_data),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready),
    .m_data_o (m_data_o)
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [DW-1:0] sbq[$];
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d = '0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset drops every held entry.
  initial forever begin
    @(posedge arst);
    sbq.delete();
    held_v = 1'b0;
  end

  // Monitor: inputs are stable mid-cycle, so the negedge sees exactly
  // what the next rising edge will transfer.
  initial forever begin
    @(negedge clk);
    if (!arst) begin
      if (held_v && m_valid_o)
        chk("stall_hold", m_data_o, held_d);
      held_v = m_valid_o && !m_ready && !flush;
      held_d = m_data_o;
      if (m_valid_o && m_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", m_data_o);
        end else begin
          chk("sb_data", m_data_o, sbq.pop_front());
        end
      end
      if (flush)
        sbq.delete();
      else if (s_valid && s_ready_o)
        sbq.push_back(s_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst    = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    #3;
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_s_ready", s_ready_o, 1);
    chk("rst_m_data", m_data_o, 0);
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    chk("rst_cnt", stall_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #2;
    arst = 1'b0;
    step();

    // Streaming
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      step();
      chk("stream_s_ready", s_ready_o, 1);
      chk("stream_m_valid", m_valid_o, 1);
      chk("stream_data", m_data_o, i);
    end
    s_valid = 1'b0;
    step();
    chk("stream_end_valid", m_valid_o, 0);
    chk("stream_count", n_out, 16);

    // Back-pressure
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h11;
    step();
    chk("bp_first", m_data_o, 16'h11);
    chk("bp_ready1", s_ready_o, 1);
    s_data = 16'h22;
    step();
    chk("bp_ready_low", s_ready_o, 0);
    s_data = 16'h33;
    repeat (3) begin
      step();
      chk("bp_stall_data", m_data_o, 16'h11);
      chk("bp_stall_ready", s_ready_o, 0);
    end
    m_ready = 1'b1;
    step();
    chk("bp_drain1", m_data_o, 16'h22);
    chk("bp_ready_up", s_ready_o, 1);
    step();
    chk("bp_drain2", m_data_o, 16'h33);
    s_valid = 1'b0;
    step();
    chk("bp_empty", m_valid_o, 0);

    // Flush while FULL
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h77;
    step();
    s_data = 16'h88;
    step();
    chk("fl_full", s_ready_o, 0);
    s_data = 16'h44;
    flush  = 1'b1;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("fl_m_valid", m_valid_o, 0);
    chk("fl_s_ready", s_ready_o, 1);
    chk("fl_main_hold", m_data_o, 16'h77);
    m_ready = 1'b1;
    repeat (3) begin
      step();
      chk("fl_stay_empty", m_valid_o, 0);
    end

    // Flush while BUSY discards an otherwise accepted input
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h99;
    step();
    s_data = 16'h9A;
    flush  = 1'b1;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("flb_m_valid", m_valid_o, 0);
    chk("flb_main_hold", m_data_o, 16'h99);

    // Simultaneous in/out in BUSY
    s_valid = 1'b1;
    s_data  = 16'h55;
    step();
    m_ready = 1'b1;
    s_data  = 16'h66;
    step();
    chk("sim_data", m_data_o, 16'h66);
    chk("sim_valid", m_valid_o, 1);
    chk("sim_ready", s_ready_o, 1);
    s_valid = 1'b0;
    step();
    chk("sim_empty", m_valid_o, 0);

    // Reset mid-traffic
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hB1;
    step();
    s_data = 16'hB2;
    step();
    s_valid = 1'b0;
    chk("mr_full", s_ready_o, 0);
    #1 arst = 1'b1;
    #1;
    chk("mr_m_valid", m_valid_o, 0);
    chk("mr_s_ready", s_ready_o, 1);
    chk("mr_m_data", m_data_o, 0);
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    chk("mr_cnt", stall_cnt, 0);
`endif
    #1 arst = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hA5;
    m_ready = 1'b1;
    step();
    chk("mr_a5_valid", m_valid_o, 1);
    chk("mr_a5_data", m_data_o, 16'hA5);
    s_valid = 1'b0;
    step();
    chk("mr_empty", m_valid_o, 0);

`ifdef PIPE_SKID_REG_STALL_CNT_EN
    // Stall counter
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hC3;
    step();
    s_valid = 1'b0;
    chk("cnt_start", stall_cnt, 0);
    repeat (10) step();
    chk("cnt_10", stall_cnt, 10);
    repeat (10) step();
    chk("cnt_sat", stall_cnt, 15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("cnt_flush", stall_cnt, 15);
    #1 arst = 1'b1;
    #1;
    chk("cnt_arst", stall_cnt, 0);
    #1 arst = 1'b0;
    step();
`endif

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
